// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage of the 5-stage RV32 pipeline. Owns the fetch PC, issues in-order
// word requests to instruction memory over a req/gnt/rvalid handshake, buffers
// the returned words in a small FIFO and presents them to the IF/ID register.
// A branch redirects the fetch PC, flushes the buffer and discards wrong-path
// responses that are still in flight.
//
// Optional feature (compile-time macro FETCH_PERF_CNT_EN):
//   adds perf_fetched (instructions popped) and perf_flushed (words dropped by
//   a redirect), both 32-bit wrapping counters cleared by reset.
//
// Parameters:
//   RESET_PC    first fetch address after reset
//   FIFO_DEPTH  instruction buffer entries (power of 2, >= 2)
//
// Ports:
//   clock, reset    system clock; synchronous active-high reset
//   branch          redirect request (same pulse that flushes IF/ID)
//   branch_target   redirect address; bits [1:0] are ignored
//   stall           downstream cannot accept the presented instruction
//   imem_req        fetch request valid
//   imem_addr       word-aligned fetch address
//   imem_gnt        request accepted this cycle
//   imem_rvalid     response word valid (in order, >= 1 cycle after gnt)
//   imem_rdata      response word
//   instruction     instruction to IF/ID (NOP when nothing is buffered)
//   pc_out          PC of instruction (holds last value when nothing buffered)
//   valid           instruction/pc_out carry a real instruction
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam int          PTR_W = $clog2(FIFO_DEPTH);
  localparam int          CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

  state_t             state, state_next;
  logic [31:0]        fetch_pc, resp_pc, last_pc;
  logic [CNT_W-1:0]   outstanding, discard, fifo_count, branch_discard;
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [31:0]        fifo_instr [FIFO_DEPTH];
  logic [31:0]        fifo_pc    [FIFO_DEPTH];
  logic [31:0]        target_aligned;

  logic may_issue, resp_ok, issue, empty, push, pop, drop;

  // Credits are reserved at issue: a word in flight already owns a FIFO slot,
  // so a returning response can always be pushed.
  assign may_issue = ((CNT_W+1)'(outstanding) + (CNT_W+1)'(fifo_count))
                     < (CNT_W+1)'(FIFO_DEPTH);

  // A response with nothing outstanding belongs to a pre-reset request.
  assign resp_ok        = imem_rvalid && (outstanding != '0);
  assign issue          = imem_req && imem_gnt;
  assign empty          = (fifo_count == '0);
  assign push           = (state == FETCH) && resp_ok && !branch;
  assign pop            = !empty && !stall && !branch;
  assign drop           = (state == FLUSH) && resp_ok && !branch;
  assign target_aligned = branch_target & 32'hFFFF_FFFC;

  // Everything still owed by memory after this cycle is wrong-path.
  assign branch_discard = outstanding + CNT_W'(issue) - CNT_W'(resp_ok);

  assign imem_req    = (state == FETCH) && may_issue && !branch;
  assign imem_addr   = fetch_pc;
  assign valid       = !empty;
  assign instruction = empty ? NOP     : fifo_instr[rd_ptr];
  assign pc_out      = empty ? last_pc : fifo_pc[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    state_next = FETCH;
      FETCH:   state_next = FETCH;
      // Leave as soon as the last wrong-path word arrives.
      FLUSH:   if (discard == '0 || (drop && discard == CNT_W'(1)))
                 state_next = FETCH;
      default: state_next = IDLE;
    endcase
    if (branch) state_next = (branch_discard != '0) ? FLUSH : FETCH;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      fifo_count  <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      last_pc     <= '0;
    end else begin
      if (!empty) last_pc <= fifo_pc[rd_ptr];
      if (branch) begin
        fetch_pc    <= target_aligned;
        resp_pc     <= target_aligned;
        outstanding <= branch_discard;
        discard     <= branch_discard;
        fifo_count  <= '0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
      end else begin
        if (issue) fetch_pc <= fetch_pc + 32'd4;
        outstanding <= outstanding + CNT_W'(issue) - CNT_W'(resp_ok);
        if (push) begin
          resp_pc <= resp_pc + 32'd4;
          wr_ptr  <= wr_ptr + PTR_W'(1);
        end
        if (pop)  rd_ptr  <= rd_ptr + PTR_W'(1);
        if (drop) discard <= discard - CNT_W'(1);
        fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // NOTE: buffer storage is not reset; fifo_count gates every read, so stale
  // contents are never visible and the array can map to plain storage.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      fifo_instr[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]    <= resp_pc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Flushed words: buffered words plus a response landing in the redirect
  // cycle, then each wrong-path response drained in FLUSH.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (pop) perf_fetched <= perf_fetched + 32'd1;
      if (branch)
        perf_flushed <= perf_flushed + 32'(fifo_count) + 32'(resp_ok);
      else if (drop)
        perf_flushed <= perf_flushed + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Self-checking bench for instr_fetch_unit. A memory model answers requests
// with an address-derived word after a programmable latency. A stream-level
// reference tracks which PC must be presented next and which address must be
// requested next; a compare process checks the outputs every cycle. Directed
// sequences pin reset values, redirects, alignment, wrap, stall and grant hold.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clock, reset, branch, stall;
  logic [31:0] branch_target;
  logic        imem_req, imem_gnt, imem_rvalid, valid;
  logic [31:0] imem_addr, imem_rdata, instruction, pc_out;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif

  instr_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .branch(branch),
    .branch_target(branch_target), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instruction(instruction), .pc_out(pc_out), .valid(valid)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // ---------------- memory model ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t mq[$];
  int    cyc     = 0;
  int    mem_lat = 1;
  bit    gnt_en  = 1'b0;
  bit    spur    = 1'b0;

  // Handshakes are sampled mid-cycle, when everything has settled.
  initial begin : mem_sample
    mreq_t e;
    forever begin
      @(negedge clock);
      if (reset) mq.delete();
      else if (imem_req && imem_gnt) begin
        e.addr = imem_addr;
        e.due  = cyc + mem_lat;
        mq.push_back(e);
      end
    end
  end

  initial begin : mem_drive
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(posedge clock);
      cyc++;
      #2;
      imem_gnt = gnt_en;
      if (spur) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
      end else if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
    end
  end

  // ---------------- stream-level reference + compare ----------------
  logic [31:0] exp_pc, exp_fetch, exp_last_pc;
  bit          hold;
  int          pops, grants;

  initial begin : compare
    forever begin
      @(negedge clock);
      if (reset) begin
        exp_pc      = RESET_PC;
        exp_fetch   = RESET_PC;
        exp_last_pc = '0;
        hold        = 1'b0;
        pops        = 0;
        grants      = 0;
      end else begin
        if (valid) begin
          check("stream_pc", pc_out, exp_pc);
          check("stream_instr", instruction, mem_word(exp_pc));
        end else begin
          check("empty_nop", instruction, NOP);
          check("empty_pc_hold", pc_out, exp_last_pc);
        end
        if (branch)    check("req_low_on_branch", imem_req, 1'b0);
        else if (hold) check("req_held_until_gnt", imem_req, 1'b1);
        if (imem_req)  check("req_addr", imem_addr, exp_fetch);

        if (valid) exp_last_pc = exp_pc;
        hold = imem_req && !imem_gnt;
        if (branch) begin
          exp_pc    = branch_target & 32'hFFFF_FFFC;
          exp_fetch = branch_target & 32'hFFFF_FFFC;
        end else begin
          if (valid && !stall) begin
            exp_pc = exp_pc + 32'd4;
            pops++;
          end
          if (imem_req && imem_gnt) begin
            exp_fetch = exp_fetch + 32'd4;
            grants++;
          end
        end
      end
    end
  end

  // ---------------- directed sequence helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid_pc(input logic [31:0] want, input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (valid) begin
        check(name, pc_out, want);
        return;
      end
    end
    fail_timeout(name);
  endtask

  task automatic wait_req_addr(input logic [31:0] want, input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (imem_req) begin
        check(name, imem_addr, want);
        return;
      end
    end
    fail_timeout(name);
  endtask

  task automatic do_branch(input logic [31:0] target);
    tick();
    branch        = 1'b1;
    branch_target = target;
    tick();
    branch        = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit found;
    reset         = 1'b1;
    branch        = 1'b0;
    branch_target = '0;
    stall         = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Cycle 0 (IDLE): reset values.
    @(negedge clock);
    check("rst_valid", valid, 1'b0);
    check("rst_instr", instruction, NOP);
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_req", imem_req, 1'b0);
    check("rst_addr", imem_addr, RESET_PC);

    // Cycles 1-4: grant withheld, request held at address 0.
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("nognt_req", imem_req, 1'b1);
      check("nognt_addr", imem_addr, 32'h0);
    end
    tick();
    gnt_en = 1'b1;

    wait_valid_pc(32'h0, "first_pc0");
    wait_valid_pc(32'h4, "first_pc4");
    wait_valid_pc(32'h8, "first_pc8");
    wait_valid_pc(32'hC, "first_pcC");

    // Stall for 5 cycles: buffer fills, credits run out.
    tick();
    stall = 1'b1;
    repeat (4) tick();
    @(negedge clock);
    check("stall_req_off", imem_req, 1'b0);
    check("stall_valid", valid, 1'b1);
    tick();
    stall = 1'b0;
    @(negedge clock);
    check("release_buf0", valid, 1'b1);
    @(negedge clock);
    check("release_buf1", valid, 1'b1);
    @(negedge clock);
    check("release_buf_drained", valid, 1'b0);

    // Redirect with exactly two requests in flight.
    mem_lat = 3;
    found   = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (mq.size() == 2 && mq[0].due > cyc) found = 1'b1;
    end
    if (!found) fail_timeout("two_outstanding");
    branch        = 1'b1;
    branch_target = 32'h0000_0100;
    @(negedge clock);
    check("br_cycle_req", imem_req, 1'b0);
    tick();
    branch = 1'b0;
    @(negedge clock);
    check("flush1_req", imem_req, 1'b0);
    @(negedge clock);
    check("flush2_req", imem_req, 1'b0);
    @(negedge clock);
    check("post_flush_req", imem_req, 1'b1);
    check("post_flush_addr", imem_addr, 32'h0000_0100);
    wait_valid_pc(32'h0000_0100, "post_flush_pc");
    mem_lat = 1;

    // Misaligned target is silently aligned.
    do_branch(32'h0000_0203);
    wait_req_addr(32'h0000_0200, "align_addr");
    wait_valid_pc(32'h0000_0200, "align_pc");

    // Address wrap at the top of the space.
    do_branch(32'hFFFF_FFFC);
    wait_valid_pc(32'hFFFF_FFFC, "wrap_pc_top");
    wait_valid_pc(32'h0000_0000, "wrap_pc_zero");

    // Reset mid-stream, then a stale response in the IDLE cycle.
    wait_valid_pc(32'h0000_0004, "pre_reset_pc");
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    spur  = 1'b1;
    @(negedge clock);
    check("midrst_valid", valid, 1'b0);
    check("midrst_instr", instruction, NOP);
    check("midrst_pc_out", pc_out, 32'h0);
    check("midrst_req", imem_req, 1'b0);
    tick();
    spur = 1'b0;
    wait_valid_pc(RESET_PC, "post_reset_pc0");
    wait_valid_pc(RESET_PC + 32'd4, "post_reset_pc4");

`ifdef FETCH_PERF_CNT_EN
    // Fill the buffer, stop granting, then flush and let everything drain.
    repeat (6) tick();
    stall = 1'b1;
    repeat (4) tick();
    gnt_en = 1'b0;
    do_branch(32'h0000_0040);
    stall = 1'b0;
    repeat (8) tick();
    @(negedge clock);
    check("perf_fetched", perf_fetched, 32'(pops));
    check("perf_flushed", perf_flushed, 32'(grants - pops));
    gnt_en = 1'b1;
`endif

    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
